// File: rtl/cam_reg_sequencer.sv
// Table-driven SCCB register sequencer: walks a synchronous ROM of write/delay/end
// entries, issues one byte-engine transaction per write, retries NACKs, repeats per camera.
module cam_reg_sequencer #(
    parameter int         NUM_CAM     = 2,
    parameter int         CAM_W       = 1,
    parameter int         IDX_W       = 8,
    parameter logic [7:0] DEV_ADDR    = 8'h78,
    parameter int         MS_CYCLES   = 25000,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic             clk_25M,
    input  logic             camera_rst,
    input  logic             start,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [25:0]      rom_data,
    output logic [CAM_W-1:0] cam_sel,
    output logic             i2c_req,
    output logic [7:0]       i2c_dev_addr,
    output logic [15:0]      i2c_reg_addr,
    output logic [7:0]       i2c_wdata,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             busy,
    output logic             reg_conf_done,
    output logic             cfg_err,
    output logic [CAM_W-1:0] err_cam,
    output logic [IDX_W-1:0] err_index
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_GAP,
        S_DELAY,
        S_ADVANCE,
        S_NEXT_CAM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [CAM_W-1:0] LAST_CAM  = CAM_W'(NUM_CAM - 1);
    localparam logic [31:0]      MS_C      = 32'(MS_CYCLES);
    localparam logic [31:0]      TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      RETRY_LIM = 32'(MAX_RETRY);

    state_t      state;
    state_t      next_state;
    logic [1:0]  op;
    logic [31:0] dly_cnt;
    logic [31:0] tmo_cnt;
    logic [31:0] retry_cnt;
    logic        attempt_fail;
    logic        can_start;

    assign op           = rom_data[25:24];
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_req      = (state == S_WRITE);
    assign can_start    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

    // A timed-out attempt is treated exactly like a NACK.
    assign attempt_fail = (state == S_WRITE) &&
                          ((i2c_done && i2c_nack) || (!i2c_done && (tmo_cnt == TMO_LAST)));

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    2'b00:   next_state = S_WRITE;
                    2'b01:   next_state = S_DELAY;
                    2'b11:   next_state = S_NEXT_CAM;
                    default: next_state = S_ADVANCE;
                endcase
            end
            S_WRITE: begin
                if (attempt_fail)
                    next_state = (retry_cnt < RETRY_LIM) ? S_GAP : S_ERROR;
                else if (i2c_done)
                    next_state = S_ADVANCE;
            end
            S_GAP: next_state = S_WRITE;
            S_DELAY: begin
                if (dly_cnt <= 32'd1) next_state = S_ADVANCE;
            end
            S_ADVANCE: begin
                next_state = (rom_addr == '1) ? S_NEXT_CAM : S_FETCH;
            end
            S_NEXT_CAM: begin
                next_state = (cam_sel < LAST_CAM) ? S_FETCH : S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25M or posedge camera_rst) begin
        if (camera_rst) begin
            state         <= S_IDLE;
            rom_addr      <= '0;
            cam_sel       <= '0;
            i2c_reg_addr  <= '0;
            i2c_wdata     <= '0;
            busy          <= 1'b0;
            reg_conf_done <= 1'b0;
            cfg_err       <= 1'b0;
            err_cam       <= '0;
            err_index     <= '0;
            dly_cnt       <= '0;
            tmo_cnt       <= '0;
            retry_cnt     <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_DECODE: begin
                    if (op == 2'b00) begin
                        i2c_reg_addr <= rom_data[23:8];
                        i2c_wdata    <= rom_data[7:0];
                        retry_cnt    <= '0;
                        tmo_cnt      <= '0;
                    end else if (op == 2'b01) begin
                        dly_cnt <= {24'd0, rom_data[7:0]} * MS_C;
                    end
                end
                S_WRITE: begin
                    if (next_state == S_WRITE) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end else begin
                        tmo_cnt <= '0;
                        if (attempt_fail) retry_cnt <= retry_cnt + 32'd1;
                        if (next_state == S_ERROR) begin
                            cfg_err   <= 1'b1;
                            busy      <= 1'b0;
                            err_cam   <= cam_sel;
                            err_index <= rom_addr;
                        end
                    end
                end
                S_DELAY: dly_cnt <= dly_cnt - 32'd1;
                S_ADVANCE: begin
                    // The last table slot ends the camera instead of wrapping.
                    if (rom_addr != '1) rom_addr <= rom_addr + IDX_W'(1);
                end
                S_NEXT_CAM: begin
                    if (cam_sel < LAST_CAM) begin
                        cam_sel  <= cam_sel + CAM_W'(1);
                        rom_addr <= '0;
                    end else begin
                        busy          <= 1'b0;
                        reg_conf_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (can_start && start) begin
                rom_addr      <= '0;
                cam_sel       <= '0;
                busy          <= 1'b1;
                reg_conf_done <= 1'b0;
                cfg_err       <= 1'b0;
                err_cam       <= '0;
                err_index     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Directed bench for cam_reg_sequencer: ROM model plus scripted byte-engine responses.
`timescale 1ns/1ps
module tb_cam_reg_sequencer;

    localparam int IDX_W = 3;
    localparam int CAM_W = 1;
    localparam int MS    = 10;

    logic             clk_25M = 1'b0;
    logic             camera_rst = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] rom_addr;
    logic [25:0]      rom_data;
    logic [CAM_W-1:0] cam_sel;
    logic             i2c_req;
    logic [7:0]       i2c_dev_addr;
    logic [15:0]      i2c_reg_addr;
    logic [7:0]       i2c_wdata;
    logic             i2c_done = 1'b0;
    logic             i2c_nack = 1'b0;
    logic             busy;
    logic             reg_conf_done;
    logic             cfg_err;
    logic [CAM_W-1:0] err_cam;
    logic [IDX_W-1:0] err_index;

    logic [25:0] rom [8];
    int n_cmp = 0;
    int n_bad = 0;

    cam_reg_sequencer #(
        .NUM_CAM(2), .CAM_W(CAM_W), .IDX_W(IDX_W), .DEV_ADDR(8'h78),
        .MS_CYCLES(MS), .MAX_RETRY(3), .TIMEOUT_CYC(100)
    ) dut (
        .clk_25M(clk_25M), .camera_rst(camera_rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .cam_sel(cam_sel),
        .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
        .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .busy(busy), .reg_conf_done(reg_conf_done), .cfg_err(cfg_err),
        .err_cam(err_cam), .err_index(err_index)
    );

    always #20 clk_25M = ~clk_25M;

    always @(posedge clk_25M) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_25M);
        start = 1'b1;
        @(negedge clk_25M);
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag, output int cyc);
        cyc = 0;
        while (i2c_req !== 1'b1 && cyc < 2000) begin
            @(negedge clk_25M);
            cyc++;
        end
        if (i2c_req !== 1'b1) check({tag, " req_wait"}, 32'(i2c_req), 1);
    endtask

    task automatic serve(input string tag, input logic [15:0] ra, input logic [7:0] wd,
                         input logic [CAM_W-1:0] cs, input logic nack, output int gap);
        wait_req(tag, gap);
        check({tag, " reg"}, 32'(i2c_reg_addr), 32'(ra));
        check({tag, " wdata"}, 32'(i2c_wdata), 32'(wd));
        check({tag, " cam"}, 32'(cam_sel), 32'(cs));
        repeat (2) @(negedge clk_25M);
        i2c_done = 1'b1;
        i2c_nack = nack;
        @(negedge clk_25M);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        check({tag, " req_drop"}, 32'(i2c_req), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (reg_conf_done !== 1'b1 && n < 100) begin
            @(negedge clk_25M);
            n++;
        end
        check({tag, " done"}, 32'(reg_conf_done), 1);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " err"}, 32'(cfg_err), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rom_addr"}, 32'(rom_addr), 0);
        check({tag, " cam_sel"}, 32'(cam_sel), 0);
        check({tag, " req"}, 32'(i2c_req), 0);
        check({tag, " dev"}, 32'(i2c_dev_addr), 'h78);
        check({tag, " reg"}, 32'(i2c_reg_addr), 0);
        check({tag, " wdata"}, 32'(i2c_wdata), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(reg_conf_done), 0);
        check({tag, " err"}, 32'(cfg_err), 0);
        check({tag, " err_cam"}, 32'(err_cam), 0);
        check({tag, " err_idx"}, 32'(err_index), 0);
    endtask

    initial begin
        int g;
        int hi;
        for (int i = 0; i < 8; i++) rom[i] = '0;

        #5 camera_rst = 1'b1;
        repeat (3) @(negedge clk_25M);
        check_reset_outputs("rst");
        camera_rst = 1'b0;

        // Write, 5 ms delay, write, end; both cameras acked.
        rom[0] = {2'b00, 16'h3008, 8'h82};
        rom[1] = {2'b01, 16'h0000, 8'd5};
        rom[2] = {2'b00, 16'h3103, 8'h03};
        rom[3] = {2'b11, 24'h0};
        pulse_start();
        check("t1 busy", 32'(busy), 1);
        serve("t1 c0w0", 16'h3008, 8'h82, 1'b0, 1'b0, g);
        serve("t1 c0w1", 16'h3103, 8'h03, 1'b0, 1'b0, g);
        check("t1 c0 delay", 32'(g >= 5 * MS && g <= 5 * MS + 10), 1);
        serve("t1 c1w0", 16'h3008, 8'h82, 1'b1, 1'b0, g);
        serve("t1 c1w1", 16'h3103, 8'h03, 1'b1, 1'b0, g);
        check("t1 c1 delay", 32'(g >= 5 * MS && g <= 5 * MS + 10), 1);
        wait_done("t1");

        // Second write NACKed twice, then acked.
        rom[0] = {2'b00, 16'h3008, 8'h82};
        rom[1] = {2'b00, 16'h3103, 8'h03};
        rom[2] = {2'b11, 24'h0};
        rom[3] = '0;
        pulse_start();
        check("t2 done_clr", 32'(reg_conf_done), 0);
        serve("t2 c0w0", 16'h3008, 8'h82, 1'b0, 1'b0, g);
        serve("t2 try1", 16'h3103, 8'h03, 1'b0, 1'b1, g);
        serve("t2 try2", 16'h3103, 8'h03, 1'b0, 1'b1, g);
        check("t2 gap1", 32'(g), 1);
        serve("t2 try3", 16'h3103, 8'h03, 1'b0, 1'b0, g);
        check("t2 gap2", 32'(g), 1);
        serve("t2 c1w0", 16'h3008, 8'h82, 1'b1, 1'b0, g);
        serve("t2 c1w1", 16'h3103, 8'h03, 1'b1, 1'b0, g);
        wait_done("t2");

        // Entry 1 on camera 1 NACKed four times -> abort.
        pulse_start();
        serve("t3 c0w0", 16'h3008, 8'h82, 1'b0, 1'b0, g);
        serve("t3 c0w1", 16'h3103, 8'h03, 1'b0, 1'b0, g);
        serve("t3 c1w0", 16'h3008, 8'h82, 1'b1, 1'b0, g);
        for (int a = 0; a < 4; a++) begin
            serve("t3 nack", 16'h3103, 8'h03, 1'b1, 1'b1, g);
            if (a > 0) check("t3 gap", 32'(g), 1);
        end
        check("t3 err", 32'(cfg_err), 1);
        check("t3 err_cam", 32'(err_cam), 1);
        check("t3 err_idx", 32'(err_index), 1);
        check("t3 done", 32'(reg_conf_done), 0);
        check("t3 busy", 32'(busy), 0);
        repeat (3) @(negedge clk_25M);
        check("t3 no_retry", 32'(i2c_req), 0);
        pulse_start();
        check("t3r err", 32'(cfg_err), 0);
        check("t3r err_cam", 32'(err_cam), 0);
        check("t3r err_idx", 32'(err_index), 0);
        check("t3r busy", 32'(busy), 1);
        check("t3r cam", 32'(cam_sel), 0);
        check("t3r addr", 32'(rom_addr), 0);
        serve("t3r c0w0", 16'h3008, 8'h82, 1'b0, 1'b0, g);
        serve("t3r c0w1", 16'h3103, 8'h03, 1'b0, 1'b0, g);
        serve("t3r c1w0", 16'h3008, 8'h82, 1'b1, 1'b0, g);
        serve("t3r c1w1", 16'h3103, 8'h03, 1'b1, 1'b0, g);
        wait_done("t3r");

        // No i2c_done at all: four 100-cycle attempts, then abort.
        pulse_start();
        for (int a = 0; a < 4; a++) begin
            wait_req("t4", g);
            if (a > 0) check("t4 gap", 32'(g), 1);
            hi = 0;
            while (i2c_req === 1'b1 && hi < 300) begin
                @(negedge clk_25M);
                hi++;
            end
            check("t4 attempt_len", 32'(hi), 100);
        end
        check("t4 err", 32'(cfg_err), 1);
        check("t4 err_cam", 32'(err_cam), 0);
        check("t4 err_idx", 32'(err_index), 0);
        check("t4 done", 32'(reg_conf_done), 0);
        check("t4 busy", 32'(busy), 0);

        // Table with no end marker fills all 8 slots.
        for (int i = 0; i < 8; i++) rom[i] = {2'b00, 16'h4000 + 16'(i), 8'(i + 16)};
        pulse_start();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++)
                serve("t5 w", 16'h4000 + 16'(i), 8'(i + 16), CAM_W'(c), 1'b0, g);
        wait_done("t5");
        check("t5 no_wrap", 32'(rom_addr), 7);
        check("t5 cam", 32'(cam_sel), 1);

        // start while busy is ignored; reset mid-transaction clears everything at once.
        pulse_start();
        wait_req("t6", g);
        start = 1'b1;
        @(negedge clk_25M);
        start = 1'b0;
        check("t6 req_kept", 32'(i2c_req), 1);
        check("t6 busy", 32'(busy), 1);
        check("t6 addr", 32'(rom_addr), 0);
        check("t6 reg", 32'(i2c_reg_addr), 'h4000);
        camera_rst = 1'b1;
        #1;
        check_reset_outputs("t6 rst");
        @(negedge clk_25M);
        camera_rst = 1'b0;
        repeat (2) @(negedge clk_25M);
        check("t6 idle_req", 32'(i2c_req), 0);
        check("t6 idle_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
